// File: rtl/ahb_busmatrix_ble_input_stage_pkg.sv
// Shared bus-matrix constants: AHB transfer/response encodings and the
// input-stage state encoding. The default slave imports this package too.
package ahb_busmatrix_ble_input_stage_pkg;

   // AHB HTRANS encodings
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   // AHB HRESP encodings
   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01,
      HRESP_RETRY = 2'b10,
      HRESP_SPLIT = 2'b11
   } hresp_e;

   // Input-stage FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,   // no transfer owned
      ST_PEND = 2'b01,   // address phase held, waiting for downstream accept
      ST_DATA = 2'b10    // address accepted, data phase in progress
   } in_state_e;

   // A transfer needs an output port only for NONSEQ/SEQ (HTRANS[1] set)
   function automatic logic trans_is_active(input logic [1:0] htrans);
      return htrans[1];
   endfunction

endpackage

// File: rtl/ahb_busmatrix_ble_input_stage_if.sv
// Bus bundle of one bus-matrix input stage: master-side AHB signals plus the
// address-phase / data-phase handshake with the decoder and output stages.
interface ahb_busmatrix_ble_input_stage_if #(
   parameter int ADDR_WIDTH = 32
);
   // master side
   logic                  HSELS;
   logic [ADDR_WIDTH-1:0] HADDRS;
   logic [1:0]            HTRANSS;
   logic                  HWRITES;
   logic [2:0]            HSIZES;
   logic [2:0]            HBURSTS;
   logic [3:0]            HPROTS;
   logic                  HMASTLOCKS;
   logic                  HREADYS;
   logic                  HREADYOUTS;
   logic [1:0]            HRESPS;
   // address phase towards decoder / output stages
   logic                  SEL_OUT;
   logic [ADDR_WIDTH-1:0] ADDR_OUT;
   logic [1:0]            TRANS_OUT;
   logic                  WRITE_OUT;
   logic [2:0]            SIZE_OUT;
   logic [2:0]            BURST_OUT;
   logic [3:0]            PROT_OUT;
   logic                  MASTLOCK_OUT;
   logic                  TRANS_REQ;
   logic                  ADDR_ACK;
   // data phase from selected slave / default slave
   logic                  ACTIVE_DEC;
   logic                  HREADYM;
   logic [1:0]            HRESPM;

   // view of the input stage itself
   modport slave (
      input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
             HMASTLOCKS, HREADYS, ADDR_ACK, ACTIVE_DEC, HREADYM, HRESPM,
      output HREADYOUTS, HRESPS, SEL_OUT, ADDR_OUT, TRANS_OUT, WRITE_OUT,
             SIZE_OUT, BURST_OUT, PROT_OUT, MASTLOCK_OUT, TRANS_REQ
   );

   // view of everything around the input stage (master + downstream)
   modport master (
      output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
             HMASTLOCKS, HREADYS, ADDR_ACK, ACTIVE_DEC, HREADYM, HRESPM,
      input  HREADYOUTS, HRESPS, SEL_OUT, ADDR_OUT, TRANS_OUT, WRITE_OUT,
             SIZE_OUT, BURST_OUT, PROT_OUT, MASTLOCK_OUT, TRANS_REQ
   );
endinterface

// File: rtl/ahb_busmatrix_ble_input_stage.sv
// Bus-matrix input stage. Passes the master address phase straight through
// when the downstream accepts it at once; otherwise parks it in an inline
// holding register and stalls the master until ADDR_ACK. During the data
// phase it forwards ready/response from whichever slave this input owns.
module ahb_busmatrix_ble_input_stage
   import ahb_busmatrix_ble_input_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                              HCLK,
   input  logic                              HRESETn,
   ahb_busmatrix_ble_input_stage_if.slave    bus
);

   in_state_e             state_r;
   in_state_e             launch_state_s;
   logic                  new_tran_s;
   logic                  eval_s;
   logic                  capture_s;
   logic                  use_hold_s;

   logic                  hold_sel_r;
   logic [ADDR_WIDTH-1:0] hold_addr_r;
   logic [1:0]            hold_trans_r;
   logic                  hold_write_r;
   logic [2:0]            hold_size_r;
   logic [2:0]            hold_burst_r;
   logic [3:0]            hold_prot_r;
   logic                  hold_mastlock_r;

   assign new_tran_s = bus.HSELS & bus.HREADYS & trans_is_active(bus.HTRANSS);

   // The current master cycle is examined in IDLE, or in DATA once the
   // owned data phase completes, so back-to-back beats need no idle gap.
   assign eval_s = (state_r == ST_IDLE) |
                   ((state_r == ST_DATA) & bus.ACTIVE_DEC & bus.HREADYM);

   assign capture_s  = eval_s & new_tran_s & ~bus.ADDR_ACK;
   assign use_hold_s = (state_r == ST_PEND) | ~HRESETn;

   // Next state when a new master cycle is evaluated
   always_comb begin
      launch_state_s = ST_IDLE;
      if (new_tran_s) begin
         if (bus.ADDR_ACK) begin
            launch_state_s = ST_DATA;
         end else begin
            launch_state_s = ST_PEND;
         end
      end else begin
         launch_state_s = ST_IDLE;
      end
   end

   // Input-stage FSM
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: state_r <= launch_state_s;
            ST_PEND: begin
               if (bus.ADDR_ACK) begin
                  state_r <= ST_DATA;
               end else begin
                  state_r <= ST_PEND;
               end
            end
            ST_DATA: begin
               if (eval_s) begin
                  state_r <= launch_state_s;
               end else begin
                  state_r <= ST_DATA;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Holding register: loaded only on the cycle a transfer goes pending,
   // frozen while pending, cleared (TRANS=IDLE) by reset
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         hold_sel_r      <= 1'b0;
         hold_addr_r     <= '0;
         hold_trans_r    <= HTRANS_IDLE;
         hold_write_r    <= 1'b0;
         hold_size_r     <= 3'b000;
         hold_burst_r    <= 3'b000;
         hold_prot_r     <= 4'b0000;
         hold_mastlock_r <= 1'b0;
      end else if (capture_s) begin
         hold_sel_r      <= bus.HSELS;
         hold_addr_r     <= bus.HADDRS;
         hold_trans_r    <= bus.HTRANSS;
         hold_write_r    <= bus.HWRITES;
         hold_size_r     <= bus.HSIZES;
         hold_burst_r    <= bus.HBURSTS;
         hold_prot_r     <= bus.HPROTS;
         hold_mastlock_r <= bus.HMASTLOCKS;
      end else begin
         hold_sel_r      <= hold_sel_r;
         hold_addr_r     <= hold_addr_r;
         hold_trans_r    <= hold_trans_r;
         hold_write_r    <= hold_write_r;
         hold_size_r     <= hold_size_r;
         hold_burst_r    <= hold_burst_r;
         hold_prot_r     <= hold_prot_r;
         hold_mastlock_r <= hold_mastlock_r;
      end
   end

   // Address-phase mux: held copy while pending (or in reset, where the
   // cleared register presents an IDLE transfer), otherwise live master bus
   always_comb begin
      bus.SEL_OUT      = bus.HSELS;
      bus.ADDR_OUT     = bus.HADDRS;
      bus.TRANS_OUT    = bus.HTRANSS;
      bus.WRITE_OUT    = bus.HWRITES;
      bus.SIZE_OUT     = bus.HSIZES;
      bus.BURST_OUT    = bus.HBURSTS;
      bus.PROT_OUT     = bus.HPROTS;
      bus.MASTLOCK_OUT = bus.HMASTLOCKS;
      if (use_hold_s) begin
         bus.SEL_OUT      = hold_sel_r;
         bus.ADDR_OUT     = hold_addr_r;
         bus.TRANS_OUT    = hold_trans_r;
         bus.WRITE_OUT    = hold_write_r;
         bus.SIZE_OUT     = hold_size_r;
         bus.BURST_OUT    = hold_burst_r;
         bus.PROT_OUT     = hold_prot_r;
         bus.MASTLOCK_OUT = hold_mastlock_r;
      end else begin
         bus.SEL_OUT      = bus.HSELS;
         bus.ADDR_OUT     = bus.HADDRS;
         bus.TRANS_OUT    = bus.HTRANSS;
         bus.WRITE_OUT    = bus.HWRITES;
         bus.SIZE_OUT     = bus.HSIZES;
         bus.BURST_OUT    = bus.HBURSTS;
         bus.PROT_OUT     = bus.HPROTS;
         bus.MASTLOCK_OUT = bus.HMASTLOCKS;
      end
   end

   // Port request and master-side ready/response
   always_comb begin
      bus.TRANS_REQ  = 1'b0;
      bus.HREADYOUTS = 1'b1;
      bus.HRESPS     = HRESP_OKAY;
      if (!HRESETn) begin
         bus.TRANS_REQ  = 1'b0;
         bus.HREADYOUTS = 1'b1;
         bus.HRESPS     = HRESP_OKAY;
      end else begin
         case (state_r)
            ST_PEND: begin
               bus.TRANS_REQ  = 1'b1;
               bus.HREADYOUTS = 1'b0;
               bus.HRESPS     = HRESP_OKAY;
            end
            ST_DATA: begin
               bus.TRANS_REQ = eval_s & new_tran_s;
               if (bus.ACTIVE_DEC) begin
                  bus.HREADYOUTS = bus.HREADYM;
                  bus.HRESPS     = bus.HRESPM;
               end else begin
                  bus.HREADYOUTS = 1'b1;
                  bus.HRESPS     = HRESP_OKAY;
               end
            end
            ST_IDLE: begin
               bus.TRANS_REQ  = new_tran_s;
               bus.HREADYOUTS = 1'b1;
               bus.HRESPS     = HRESP_OKAY;
            end
            default: begin
               bus.TRANS_REQ  = 1'b0;
               bus.HREADYOUTS = 1'b1;
               bus.HRESPS     = HRESP_OKAY;
            end
         endcase
      end
   end

endmodule

// File: doc/ahb_busmatrix_ble_input_stage.md
AHB_BUSMATRIX_BLE_INPUT_STAGE -- requirements
Module: AHB_BusMatrix_BLE_input_stage

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning address bus width.
REQ-002 The block SHALL have ports (name  direction  width  meaning):
  HCLK  in  1  AHB system clock; the single clock;
  HRESETn  in  1  asynchronous active-low reset;
  HSELS  in  1  master-side slave select;
  HADDRS  in  ADDR_WIDTH  master address;
  HTRANSS  in  2  master transfer type;
  HWRITES  in  1  master write;
  HSIZES  in  3  master size;
  HBURSTS  in  3  master burst;
  HPROTS  in  4  master protection;
  HMASTLOCKS  in  1  master lock;
  HREADYS  in  1  master-side HREADY;
  HREADYOUTS  out  1  ready returned to master;
  HRESPS  out  2  response returned to master;
  SEL_OUT, ADDR_OUT[ADDR_WIDTH], TRANS_OUT[2], WRITE_OUT, SIZE_OUT[3], BURST_OUT[3], PROT_OUT[4], MASTLOCK_OUT  out  address phase presented to decoder and output stages;
  TRANS_REQ  out  1  address phase pending or live and requesting an output port;
  ADDR_ACK  in  1  downstream accepted the presented address phase this cycle;
  ACTIVE_DEC  in  1  this input owns the data phase of the selected output port or default slave;
  HREADYM  in  1  data-phase ready from selected slave or default slave;
  HRESPM  in  2  data-phase response from selected slave or default slave.

Function
REQ-003 new_tran SHALL be HSELS & HREADYS & HTRANSS[1].
REQ-004 The FSM SHALL have states IDLE, PEND (address held, not yet accepted), DATA (accepted, data phase in progress).
REQ-005 IDLE: new_tran & ADDR_ACK -> DATA; new_tran & ~ADDR_ACK -> PEND, capturing all address-phase inputs into the holding register; otherwise stay IDLE.
REQ-006 PEND: ADDR_ACK -> DATA; otherwise stay PEND; the holding register SHALL NOT update while in PEND.
REQ-007 DATA: ACTIVE_DEC & HREADYM -> evaluate the current master cycle per REQ-005, so back-to-back transfers incur no idle cycle.
REQ-008 In PEND, the *_OUT signals SHALL come from the holding register; in all other states they SHALL pass HSELS/HADDRS/... through combinationally.
REQ-009 TRANS_REQ SHALL be 1 in PEND, and also when new_tran is 1 in IDLE or in DATA with ACTIVE_DEC & HREADYM.
REQ-010 HREADYOUTS SHALL be 0 in PEND.
REQ-011 In DATA with ACTIVE_DEC=1, HREADYOUTS SHALL equal HREADYM and HRESPS SHALL equal HRESPM.
REQ-012 In all other cases HREADYOUTS SHALL be 1 and HRESPS SHALL be OKAY (2'b00).
REQ-013 An ERROR response (HRESPM=01) SHALL be forwarded in both cycles, low-ready then high-ready, unchanged.
REQ-014 If the master issues IDLE (HTRANSS=00) during the second error cycle, no new transfer SHALL be registered.
REQ-015 A held SEQ or BUSY transfer SHALL be presented unchanged, with no type conversion.
REQ-016 If ADDR_ACK arrives in the same cycle the transfer is first seen, no holding occurs and the master sees zero added wait states.
REQ-017 Each pend SHALL add exactly one wait cycle per cycle of ADDR_ACK low.

Reset
REQ-018 On HRESETn low, asynchronously: state=IDLE, holding register cleared to 0 (TRANS=IDLE), HREADYOUTS=1, HRESPS=OKAY, TRANS_REQ=0.
REQ-019 Reset asserted mid-PEND or mid-DATA SHALL discard the held transfer; the first cycle after release SHALL behave as IDLE.

Structure
REQ-020 HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP encodings (OKAY/ERROR/RETRY/SPLIT) and FSM state encodings SHALL live in the shared busmatrix constants package, and the default slave SHALL use the same package.
REQ-021 The block SHALL be a single module with no sub-modules; the holding register SHALL be inline.

Verification
REQ-022 Each scenario below SHALL be covered by a directed test.
- Direct accept: NONSEQ at 0x2000_0010 with ADDR_ACK=1 -> ADDR_OUT=0x2000_0010 in the same cycle, HREADYOUTS=1, next state DATA.
- Hold: NONSEQ at 0x4000_0000 with ADDR_ACK low for 3 cycles -> HREADYOUTS=0 for 3 cycles; ADDR_OUT stays 0x4000_0000 while HADDRS changes; DATA on the 4th cycle.
- Error pass-through: DATA with HRESPM=01, HREADYM 0 then 1 -> HRESPS=01 for 2 cycles, HREADYOUTS=0 then 1.
- Back-to-back: 4-beat INCR4 with ADDR_ACK=1 and HREADYM=1 -> 4 accepts in 4 cycles, no IDLE state between beats.
- Reset in PEND: HRESETn low for 1 cycle while holding 0x1234_5678 -> HREADYOUTS=1, TRANS_REQ=0, TRANS_OUT=00 immediately.
